// File: rtl/tdc_meas_ctrl.sv
// tdc_meas_ctrl
// Measurement sequencer for one NAND ring-oscillator TDC channel.
// Detects a hit rise, enables the ring, strobes the TOA and TOT latch banks,
// stops and drains the ring, then holds the coarse counts until readout
// accepts them over Valid/Ready.
//
// Optional feature: define TDC_CTRL_CAL_EN to let Cal_Req launch an internal
// calibration pulse of CAL_WIDTH cycles in place of the external Hit.
//
// Parameter ranges:
//   1 <= TOA_DLY <= 2^CNT_W-2
//   TOA_DLY < TOT_MAX < 2^CNT_W
//   DRAIN_CYC >= 1
//
// state     | meaning
// ----------+----------------------------------------------------------
// IDLE      | ring off, waiting for a hit rise (or calibration request)
// TOA_WAIT  | ring running, counting up to the TOA capture point
// TOT_WAIT  | ring running, waiting for the hit to fall or TOT_MAX
// DRAIN     | ring stopped, letting the delay line settle
// OUT       | result presented on Valid, waiting for Ready

module tdc_meas_ctrl #(
    parameter int CNT_W     = 8,
    parameter int TOA_DLY   = 4,
    parameter int TOT_MAX   = 200,
    parameter int DRAIN_CYC = 3,
    parameter int CAL_WIDTH = 16
) (
    input  logic             Clk,
    input  logic             RSTn,
    input  logic             Hit,
    input  logic             Cal_Req,
    output logic             Start,
    output logic             TOA_Capture,
    output logic             TOT_Capture,
    output logic [CNT_W-1:0] Coarse_TOA,
    output logic [CNT_W-1:0] Coarse_TOT,
    output logic             Timeout,
    output logic             Cal_Flag,
    output logic             Valid,
    input  logic             Ready,
    output logic             Busy,
    output logic [7:0]       Miss_Cnt
);

    localparam logic [2:0] ST_IDLE     = 3'd0;
    localparam logic [2:0] ST_TOA_WAIT = 3'd1;
    localparam logic [2:0] ST_TOT_WAIT = 3'd2;
    localparam logic [2:0] ST_DRAIN    = 3'd3;
    localparam logic [2:0] ST_OUT      = 3'd4;

    localparam int DRN_W = (DRAIN_CYC < 2) ? 1 : $clog2(DRAIN_CYC + 1);

    // Counter value seen at the edge that fires the TOA strobe.
    localparam logic [CNT_W-1:0] TOA_LAST = CNT_W'(TOA_DLY - 1);
    localparam logic [CNT_W-1:0] TOA_VAL  = CNT_W'(TOA_DLY);
    // Counter value seen at the edge that forces a TOT timeout.
    localparam logic [CNT_W-1:0] TOT_LAST = CNT_W'(TOT_MAX - 1);
    localparam logic [CNT_W-1:0] TOT_VAL  = CNT_W'(TOT_MAX);
    localparam logic [DRN_W-1:0] DRN_LAST = DRN_W'(DRAIN_CYC);
    localparam logic [CNT_W:0]   CAL_LEN  = (CNT_W + 1)'(CAL_WIDTH);

    logic [2:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [DRN_W-1:0] drn_q, drn_d;
    logic             hit_dly_q, hit_dly_d;
    logic             start_q, start_d;
    logic             toa_cap_q, toa_cap_d;
    logic             tot_cap_q, tot_cap_d;
    logic [CNT_W-1:0] coarse_toa_q, coarse_toa_d;
    logic [CNT_W-1:0] coarse_tot_q, coarse_tot_d;
    logic             timeout_q, timeout_d;
    logic             cal_flag_q, cal_flag_d;
    logic             cal_run_q, cal_run_d;
    logic             valid_q, valid_d;
    logic             busy_q, busy_d;
    logic [7:0]       miss_q, miss_d;

    logic             hit_rise;
    logic             cal_start;
    logic             cal_miss;
    logic [CNT_W:0]   cnt_ext;
    logic             cal_pulse;
    logic             meas_level;
    logic             miss_evt;

    // Hit edge detect against the one-cycle delayed copy of Hit.
    always_comb begin
        hit_dly_d = Hit;
        hit_rise  = Hit & ~hit_dly_q;
    end

`ifdef TDC_CTRL_CAL_EN
    // A calibration request only launches a run when no real hit rises in
    // the same cycle; while busy it is counted as a miss like a hit rise.
    always_comb begin
        cal_start = Cal_Req & ~hit_rise;
        cal_miss  = Cal_Req;
    end
`else
    // Calibration disabled: Cal_Req has no effect at all.
    always_comb begin
        cal_start = 1'b0;
        cal_miss  = 1'b0;
    end

    logic cal_req_unused;
    assign cal_req_unused = Cal_Req;
`endif

    // Internal calibration pulse: high for CAL_WIDTH cycles from the Start
    // rise. At the m-th edge after Start rises the counter reads m-1, so the
    // pulse is still high while cnt+1 < CAL_WIDTH.
    always_comb begin
        cnt_ext    = {1'b0, cnt_q} + 1'b1;
        cal_pulse  = (cnt_ext < CAL_LEN);
        meas_level = cal_run_q ? cal_pulse : Hit;
    end

    // Saturating count of hit rises / calibration requests arriving while busy.
    always_comb begin
        miss_evt = busy_q & (hit_rise | cal_miss);
        miss_d   = miss_q;
        if (miss_evt && (miss_q != 8'hFF)) begin
            miss_d = miss_q + 8'd1;
        end
    end

    // Measurement sequencer: next state, counters, strobes and result fields.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        drn_d        = drn_q;
        start_d      = start_q;
        toa_cap_d    = 1'b0;
        tot_cap_d    = 1'b0;
        coarse_toa_d = coarse_toa_q;
        coarse_tot_d = coarse_tot_q;
        timeout_d    = timeout_q;
        cal_flag_d   = cal_flag_q;
        cal_run_d    = cal_run_q;
        valid_d      = valid_q;

        case (state_q)
            ST_IDLE: begin
                valid_d = 1'b0;
                if (hit_rise || cal_start) begin
                    state_d    = ST_TOA_WAIT;
                    start_d    = 1'b1;
                    cnt_d      = '0;
                    timeout_d  = 1'b0;
                    cal_run_d  = cal_start;
                    cal_flag_d = cal_start;
                end
            end

            ST_TOA_WAIT: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == TOA_LAST) begin
                    toa_cap_d    = 1'b1;
                    coarse_toa_d = TOA_VAL;
                    state_d      = ST_TOT_WAIT;
                end
            end

            ST_TOT_WAIT: begin
                // A falling hit takes priority over the timeout on the same edge,
                // so a hit lasting exactly TOT_MAX cycles is not flagged.
                if (!meas_level) begin
                    tot_cap_d    = 1'b1;
                    coarse_tot_d = cnt_q + 1'b1;
                    drn_d        = '0;
                    state_d      = ST_DRAIN;
                end else if (cnt_q == TOT_LAST) begin
                    tot_cap_d    = 1'b1;
                    coarse_tot_d = TOT_VAL;
                    timeout_d    = 1'b1;
                    drn_d        = '0;
                    state_d      = ST_DRAIN;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            ST_DRAIN: begin
                // Start drops on the first edge in DRAIN, one cycle after the
                // TOT strobe, then stays low for DRAIN_CYC full cycles.
                start_d = 1'b0;
                if (drn_q == DRN_LAST) begin
                    valid_d = 1'b1;
                    state_d = ST_OUT;
                end else begin
                    drn_d = drn_q + 1'b1;
                end
            end

            ST_OUT: begin
                if (valid_q && Ready) begin
                    valid_d   = 1'b0;
                    cal_run_d = 1'b0;
                    state_d   = ST_IDLE;
                end
            end

            default: begin
                state_d   = ST_IDLE;
                start_d   = 1'b0;
                valid_d   = 1'b0;
                cal_run_d = 1'b0;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge Clk) begin
        if (!RSTn) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            drn_q        <= '0;
            hit_dly_q    <= 1'b0;
            start_q      <= 1'b0;
            toa_cap_q    <= 1'b0;
            tot_cap_q    <= 1'b0;
            coarse_toa_q <= '0;
            coarse_tot_q <= '0;
            timeout_q    <= 1'b0;
            cal_flag_q   <= 1'b0;
            cal_run_q    <= 1'b0;
            valid_q      <= 1'b0;
            busy_q       <= 1'b0;
            miss_q       <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            drn_q        <= drn_d;
            hit_dly_q    <= hit_dly_d;
            start_q      <= start_d;
            toa_cap_q    <= toa_cap_d;
            tot_cap_q    <= tot_cap_d;
            coarse_toa_q <= coarse_toa_d;
            coarse_tot_q <= coarse_tot_d;
            timeout_q    <= timeout_d;
            cal_flag_q   <= cal_flag_d;
            cal_run_q    <= cal_run_d;
            valid_q      <= valid_d;
            busy_q       <= busy_d;
            miss_q       <= miss_d;
        end
    end

    assign Start       = start_q;
    assign TOA_Capture = toa_cap_q;
    assign TOT_Capture = tot_cap_q;
    assign Coarse_TOA  = coarse_toa_q;
    assign Coarse_TOT  = coarse_tot_q;
    assign Timeout     = timeout_q;
    assign Cal_Flag    = cal_flag_q;
    assign Valid       = valid_q;
    assign Busy        = busy_q;
    assign Miss_Cnt    = miss_q;

endmodule

// File: tb/tb_tdc_meas_ctrl.sv
// Testbench for tdc_meas_ctrl: directed hit pulses, scoreboarded strobe
// timing and result fields, plus direct checks of reset and miss counting.
module tb_tdc_meas_ctrl;

    localparam int CNT_W     = 8;
    localparam int TOA_DLY   = 4;
    localparam int TOT_MAX   = 200;
    localparam int DRAIN_CYC = 3;
    localparam int CAL_WIDTH = 16;

    logic             clk = 1'b0;
    logic             rstn = 1'b0;
    logic             hit = 1'b0;
    logic             cal_req = 1'b0;
    logic             ready = 1'b1;
    logic             start, toa_cap, tot_cap, timeout, cal_flag, valid, busy;
    logic [CNT_W-1:0] coarse_toa, coarse_tot;
    logic [7:0]       miss_cnt;

    int cyc = 0;
    int tests = 0;
    int fails = 0;
    bit mon_on = 1'b0;

    typedef struct packed {
        int cyc;
        int toa;
        int tot;
        int to;
        int cal;
    } res_t;

    typedef struct packed {
        int len;
        int tot;
        int to;
    } vec_t;

    int   q_rise[$];
    int   q_fall[$];
    int   q_toa[$];
    int   q_tot[$];
    res_t q_res[$];

    tdc_meas_ctrl #(
        .CNT_W(CNT_W), .TOA_DLY(TOA_DLY), .TOT_MAX(TOT_MAX),
        .DRAIN_CYC(DRAIN_CYC), .CAL_WIDTH(CAL_WIDTH)
    ) dut (
        .Clk(clk), .RSTn(rstn), .Hit(hit), .Cal_Req(cal_req),
        .Start(start), .TOA_Capture(toa_cap), .TOT_Capture(tot_cap),
        .Coarse_TOA(coarse_toa), .Coarse_TOT(coarse_tot),
        .Timeout(timeout), .Cal_Flag(cal_flag), .Valid(valid),
        .Ready(ready), .Busy(busy), .Miss_Cnt(miss_cnt)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation still running at cycle %0d, required finish", cyc);
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic unexp(input string nm);
        tests++;
        fails++;
        $display("FAIL %s: event seen at cycle %0d, expected none", nm, cyc);
    endtask

    // Expected events for a run whose Start rises at edge k.
    task automatic push_meas(input int k, input int tot, input int to, input int cal);
        res_t r;
        q_rise.push_back(k);
        q_toa.push_back(k + TOA_DLY);
        q_tot.push_back(k + tot);
        q_fall.push_back(k + tot + 1);
        r.cyc = k + tot + 1 + DRAIN_CYC;
        r.toa = TOA_DLY;
        r.tot = tot;
        r.to  = to;
        r.cal = cal;
        q_res.push_back(r);
    endtask

    task automatic wait_until(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    task automatic wait_idle();
        int n = 0;
        @(negedge clk);
        while (busy !== 1'b0 && n < 400) begin
            @(negedge clk);
            n++;
        end
        chk("idle_reached", 32'(busy), 32'd0);
        @(negedge clk);
    endtask

    task automatic run_meas(input int len, input int tot, input int to);
        int k;
        @(negedge clk);
        hit = 1'b1;
        k = cyc + 1;
        push_meas(k, tot, to, 0);
        repeat (len) @(negedge clk);
        hit = 1'b0;
        wait_idle();
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_start"},      32'(start),      32'd0);
        chk({tag, "_toa_cap"},    32'(toa_cap),    32'd0);
        chk({tag, "_tot_cap"},    32'(tot_cap),    32'd0);
        chk({tag, "_coarse_toa"}, 32'(coarse_toa), 32'd0);
        chk({tag, "_coarse_tot"}, 32'(coarse_tot), 32'd0);
        chk({tag, "_timeout"},    32'(timeout),    32'd0);
        chk({tag, "_cal_flag"},   32'(cal_flag),   32'd0);
        chk({tag, "_valid"},      32'(valid),      32'd0);
        chk({tag, "_busy"},       32'(busy),       32'd0);
        chk({tag, "_miss_cnt"},   32'(miss_cnt),   32'd0);
    endtask

    // Monitor: samples just after each rising edge and pops expectations.
    initial begin
        logic p_start;
        logic p_valid;
        res_t r;
        wait (mon_on);
        p_start = start;
        p_valid = valid;
        forever begin
            @(posedge clk);
            #1;
            if (start && !p_start) begin
                if (q_rise.size() == 0) unexp("start_rise");
                else chk("start_rise_cyc", cyc, q_rise.pop_front());
            end
            if (!start && p_start) begin
                if (q_fall.size() == 0) unexp("start_fall");
                else chk("start_fall_cyc", cyc, q_fall.pop_front());
            end
            if (toa_cap) begin
                if (q_toa.size() == 0) unexp("toa_capture");
                else chk("toa_capture_cyc", cyc, q_toa.pop_front());
            end
            if (tot_cap) begin
                if (q_tot.size() == 0) unexp("tot_capture");
                else chk("tot_capture_cyc", cyc, q_tot.pop_front());
            end
            if (p_valid && rstn) begin
                if (ready) begin
                    chk("valid_clear", 32'(valid), 32'd0);
                    if (q_res.size() != 0) q_res.delete(0);
                end else begin
                    chk("valid_hold", 32'(valid), 32'd1);
                end
            end
            if (valid) begin
                if (q_res.size() == 0) unexp("valid");
                else begin
                    r = q_res[0];
                    if (!p_valid) chk("valid_cyc", cyc, r.cyc);
                    chk("coarse_toa", 32'(coarse_toa), r.toa);
                    chk("coarse_tot", 32'(coarse_tot), r.tot);
                    chk("timeout",    32'(timeout),    r.to);
                    chk("cal_flag",   32'(cal_flag),   r.cal);
                end
            end
            p_start = start;
            p_valid = valid;
        end
    end

    // Stimulus.
    initial begin
        vec_t vecs[7];
        int   k;
        int   v;

        // len, expected Coarse_TOT, expected Timeout
        vecs = '{'{20, 20, 0}, '{2, 5, 0}, '{300, 200, 1}, '{200, 200, 0},
                 '{201, 200, 1}, '{5, 5, 0}, '{1, 5, 0}};

        rstn = 1'b0;
        repeat (3) @(negedge clk);
        chk_zero("reset");
        rstn = 1'b1;
        mon_on = 1'b1;
        @(negedge clk);

        foreach (vecs[i]) run_meas(vecs[i].len, vecs[i].tot, vecs[i].to);
        chk("miss_after_table", 32'(miss_cnt), 32'd0);

        // Readout stalls 10 cycles in OUT; a second hit rise is a miss.
        ready = 1'b0;
        @(negedge clk);
        hit = 1'b1;
        k = cyc + 1;
        push_meas(k, 20, 0, 0);
        repeat (20) @(negedge clk);
        hit = 1'b0;
        v = k + 20 + 1 + DRAIN_CYC;
        wait_until(v + 2);
        hit = 1'b1;
        @(negedge clk);
        hit = 1'b0;
        wait_until(v + 9);
        ready = 1'b1;
        wait_idle();
        chk("miss_cnt_one", 32'(miss_cnt), 32'd1);

        // Reset in TOT_WAIT aborts the run.
        @(negedge clk);
        hit = 1'b1;
        k = cyc + 1;
        q_rise.push_back(k);
        q_toa.push_back(k + TOA_DLY);
        wait_until(k + 8);
        rstn = 1'b0;
        hit = 1'b0;
        q_fall.push_back(cyc + 1);
        @(negedge clk);
        rstn = 1'b1;
        chk_zero("abort");
        @(negedge clk);
        run_meas(20, 20, 0);

`ifdef TDC_CTRL_CAL_EN
        @(negedge clk);
        cal_req = 1'b1;
        k = cyc + 1;
        push_meas(k, 16, 0, 1);
        @(negedge clk);
        cal_req = 1'b0;
        wait_idle();

        // Hit rise and Cal_Req together: hit wins, request dropped.
        @(negedge clk);
        hit = 1'b1;
        cal_req = 1'b1;
        k = cyc + 1;
        push_meas(k, 20, 0, 0);
        @(negedge clk);
        cal_req = 1'b0;
        repeat (19) @(negedge clk);
        hit = 1'b0;
        wait_idle();
`else
        @(negedge clk);
        cal_req = 1'b1;
        @(negedge clk);
        cal_req = 1'b0;
        repeat (10) @(negedge clk);
        chk("cal_ignored_busy", 32'(busy), 32'd0);
        chk("cal_ignored_start", 32'(start), 32'd0);
`endif

        repeat (5) @(negedge clk);
        chk("miss_final", 32'(miss_cnt), 32'd0);
        chk("left_rise", q_rise.size(), 32'd0);
        chk("left_fall", q_fall.size(), 32'd0);
        chk("left_toa",  q_toa.size(),  32'd0);
        chk("left_tot",  q_tot.size(),  32'd0);
        chk("left_res",  q_res.size(),  32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
